// File: rtl/ama_riscv_bp_spec.sv
`default_nettype none
// ============================================================================
// Module      : ama_riscv_bp_spec
// Description : Speculation tracker sitting directly upstream of the branch
//               predictor. Each prediction consumed at decode is queued in
//               program order. When execute resolves a branch, the outcome is
//               compared with the oldest queued prediction. The block drives
//               the predictor's enter/resolve strobes and raises
//               mispredict/redirect for the fetch and flush logic.
//
// Ports       : clk, rst          clock, synchronous active-high reset
//               dec_branch        decode holds a conditional branch
//               dec_stall         decode stalled this cycle
//               dec_pc, bp_pred   decode PC and its prediction (1 = taken)
//               exe_branch        execute resolves a branch this cycle
//               exe_pc            PC of the branch being resolved
//               exe_taken         resolved outcome
//               exe_target        computed branch target
//               spec_enter        predictor strobe: prediction consumed
//               spec_resolve      predictor strobe: branch resolved
//               br_res            resolved outcome forwarded to predictor
//               stall_req         queue full, hold decode
//               mispredict        resolved outcome differs from prediction
//               redirect_pc       correct next PC (0 unless mispredict)
//               proto_err         sticky protocol error flag
//               stat_branches     (optional) saturating resolve count
//               stat_mispred      (optional) saturating mispredict count
//
// Options     : AMA_RISCV_BP_SPEC_STATS_EN adds the two 32-bit saturating
//               statistics counters and their output ports.
//
// Revision    : 1.0 - initial release
// ============================================================================
module ama_riscv_bp_spec #(
    parameter int DEPTH = 2,
    parameter int PC_W  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            dec_branch,
    input  logic            dec_stall,
    input  logic [PC_W-1:0] dec_pc,
    input  logic            bp_pred,
    input  logic            exe_branch,
    input  logic [PC_W-1:0] exe_pc,
    input  logic            exe_taken,
    input  logic [PC_W-1:0] exe_target,
    output logic            spec_enter,
    output logic            spec_resolve,
    output logic            br_res,
    output logic            stall_req,
    output logic            mispredict,
    output logic [PC_W-1:0] redirect_pc,
    output logic            proto_err
`ifdef AMA_RISCV_BP_SPEC_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispred
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [0:0]       c_ST_RUN   = 1'b0;
    localparam logic [0:0]       c_ST_FLUSH = 1'b1;
    localparam logic [PTR_W-1:0] c_PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] c_CNT_FULL = CNT_W'(DEPTH);

    // Queue storage and bookkeeping
    logic [PC_W-1:0]  r_pc   [DEPTH];
    logic             r_pred [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic [0:0]       r_state;
    logic             r_proto_err;

    logic w_run;
    logic w_empty;
    logic w_full;
    logic w_head_match;
    logic w_valid;
    logic w_mispredict;
    logic w_pop_ok;
    logic w_enter;
    logic w_proto_hit;

    // Modulo-DEPTH increment; DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == c_PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_run        = (r_state == c_ST_RUN);
    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == c_CNT_FULL);
    assign w_head_match = (r_pc[r_head] == exe_pc);

    // A resolve is only accepted against the oldest in-flight prediction.
    assign w_valid      = w_run & exe_branch & ~w_empty & w_head_match;
    assign w_mispredict = w_valid & (r_pred[r_head] != exe_taken);
    assign w_pop_ok     = w_valid & ~w_mispredict;
    assign w_proto_hit  = w_run & exe_branch & (w_empty | ~w_head_match);

    // A correct resolve frees the head slot in the same cycle, so a full
    // queue can still accept a new prediction.
    assign w_enter = w_run & dec_branch & ~dec_stall & ~w_mispredict
                   & (~w_full | w_pop_ok);

    assign spec_enter   = w_enter;
    assign spec_resolve = w_valid;
    assign br_res       = exe_taken;
    assign stall_req    = w_run & dec_branch & w_full & ~w_pop_ok;
    assign mispredict   = w_mispredict;
    assign redirect_pc  = w_mispredict ? (exe_taken ? exe_target : exe_pc + PC_W'(4))
                                       : '0;
    assign proto_err    = r_proto_err;

    // Control state, pointers and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_RUN;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_proto_err <= 1'b0;
        end else begin
            case (r_state)
                c_ST_RUN:   r_state <= w_mispredict ? c_ST_FLUSH : c_ST_RUN;
                c_ST_FLUSH: r_state <= c_ST_RUN;
                default:    r_state <= c_ST_RUN;
            endcase

            if (w_proto_hit) begin
                r_proto_err <= 1'b1;
            end

            if (w_mispredict) begin
                // Everything younger than the head is wrong-path.
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_pop_ok) begin
                    r_head <= ptr_inc(r_head);
                end
                if (w_enter) begin
                    r_tail <= ptr_inc(r_tail);
                end
                case ({w_enter, w_pop_ok})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Entry payload; not reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (!rst && w_enter) begin
            r_pc[r_tail]   <= dec_pc;
            r_pred[r_tail] <= bp_pred;
        end
    end

`ifdef AMA_RISCV_BP_SPEC_STATS_EN
    logic [31:0] r_stat_branches;
    logic [31:0] r_stat_mispred;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_branches <= '0;
            r_stat_mispred  <= '0;
        end else begin
            if (w_valid && (r_stat_branches != 32'hFFFF_FFFF)) begin
                r_stat_branches <= r_stat_branches + 32'd1;
            end
            if (w_mispredict && (r_stat_mispred != 32'hFFFF_FFFF)) begin
                r_stat_mispred <= r_stat_mispred + 32'd1;
            end
        end
    end

    assign stat_branches = r_stat_branches;
    assign stat_mispred  = r_stat_mispred;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ama_riscv_bp_spec.sv
`default_nettype none
// ============================================================================
// Module      : tb_ama_riscv_bp_spec
// Description : Self-checking bench for ama_riscv_bp_spec. A queue-based
//               reference model predicts every output each cycle; directed
//               sequences add literal expectations, followed by randomized
//               push/resolve traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ama_riscv_bp_spec;

    localparam int DEPTH = 2;
    localparam int PC_W  = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            dec_branch, dec_stall, bp_pred;
    logic [PC_W-1:0] dec_pc;
    logic            exe_branch, exe_taken;
    logic [PC_W-1:0] exe_pc, exe_target;
    logic            spec_enter, spec_resolve, br_res, stall_req, mispredict, proto_err;
    logic [PC_W-1:0] redirect_pc;
`ifdef AMA_RISCV_BP_SPEC_STATS_EN
    logic [31:0]     stat_branches, stat_mispred;
`endif

    always #5 clk = ~clk;

    ama_riscv_bp_spec #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .dec_branch   (dec_branch),
        .dec_stall    (dec_stall),
        .dec_pc       (dec_pc),
        .bp_pred      (bp_pred),
        .exe_branch   (exe_branch),
        .exe_pc       (exe_pc),
        .exe_taken    (exe_taken),
        .exe_target   (exe_target),
        .spec_enter   (spec_enter),
        .spec_resolve (spec_resolve),
        .br_res       (br_res),
        .stall_req    (stall_req),
        .mispredict   (mispredict),
        .redirect_pc  (redirect_pc),
        .proto_err    (proto_err)
`ifdef AMA_RISCV_BP_SPEC_STATS_EN
        ,
        .stat_branches(stat_branches),
        .stat_mispred (stat_mispred)
`endif
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic            pred;
        logic [PC_W-1:0] pc;
    } ent_t;

    ent_t            q[$];
    bit              m_flush;
    bit              m_proto;
    longint unsigned m_sb, m_sm;

    bit              e_enter, e_resolve, e_stall, e_mis;
    logic [PC_W-1:0] e_redirect;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_eval();
        bit run, valid, pop_ok, full, match;
        run    = !m_flush;
        match  = (q.size() > 0) && (q[0].pc == exe_pc);
        valid  = run && exe_branch && match;
        e_mis  = valid && (q[0].pred != exe_taken);
        pop_ok = valid && !e_mis;
        full   = (q.size() == DEPTH);
        e_resolve  = valid;
        e_enter    = run && dec_branch && !dec_stall && !e_mis && (!full || pop_ok);
        e_stall    = run && dec_branch && full && !pop_ok;
        e_redirect = e_mis ? (exe_taken ? exe_target : exe_pc + 32'd4) : 32'd0;
    endfunction

    function automatic void model_update();
        bit run, match;
        if (rst) begin
            q.delete();
            m_flush = 0;
            m_proto = 0;
            m_sb = 0;
            m_sm = 0;
            return;
        end
        run   = !m_flush;
        match = (q.size() > 0) && (q[0].pc == exe_pc);
        if (run && exe_branch && !match) m_proto = 1;
        if (e_resolve && m_sb < 64'hFFFF_FFFF) m_sb++;
        if (e_mis && m_sm < 64'hFFFF_FFFF) m_sm++;
        m_flush = e_mis;
        if (e_mis) begin
            q.delete();
        end else begin
            if (e_resolve) void'(q.pop_front());
            if (e_enter) q.push_back('{pred: bp_pred, pc: dec_pc});
        end
    endfunction

    task automatic check_model();
        model_eval();
        check("spec_enter", 32'(spec_enter), 32'(e_enter));
        check("spec_resolve", 32'(spec_resolve), 32'(e_resolve));
        check("stall_req", 32'(stall_req), 32'(e_stall));
        check("mispredict", 32'(mispredict), 32'(e_mis));
        check("redirect_pc", redirect_pc, e_redirect);
        check("proto_err", 32'(proto_err), 32'(m_proto));
        if (e_resolve) check("br_res", 32'(br_res), 32'(exe_taken));
`ifdef AMA_RISCV_BP_SPEC_STATS_EN
        check("stat_branches", stat_branches, 32'(m_sb));
        check("stat_mispred", stat_mispred, 32'(m_sm));
`endif
    endtask

    // Check this cycle against the model, clock the DUT, advance the model.
    task automatic tick();
        check_model();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic drive(input bit db, input bit ds, input logic [31:0] dpc, input bit pr,
                         input bit eb, input logic [31:0] epc, input bit et,
                         input logic [31:0] etgt);
        dec_branch = db;  dec_stall = ds;  dec_pc = dpc;  bp_pred = pr;
        exe_branch = eb;  exe_pc = epc;    exe_taken = et; exe_target = etgt;
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1;
        idle();
        @(posedge clk);
        model_update();
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        rst = 1;
        idle();
        @(negedge clk);
        do_reset();

        // Reset state
        idle();
        check("rst_spec_enter", 32'(spec_enter), 0);
        check("rst_stall_req", 32'(stall_req), 0);
        check("rst_mispredict", 32'(mispredict), 0);
        check("rst_redirect_pc", redirect_pc, 0);
        check("rst_proto_err", 32'(proto_err), 0);
        tick();

        // Correct prediction
        drive(1, 0, 32'h100, 1, 0, 0, 0, 0);
        check("cp_enter", 32'(spec_enter), 1);
        tick();
        idle(); tick();
        drive(0, 0, 0, 0, 1, 32'h100, 1, 32'h180);
        check("cp_resolve", 32'(spec_resolve), 1);
        check("cp_br_res", 32'(br_res), 1);
        check("cp_mispredict", 32'(mispredict), 0);
        tick();
        check("cp_model_empty", 32'(q.size()), 0);

        // Taken mispredict with flush
        drive(1, 0, 32'h100, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 32'h104, 1, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 1, 32'h100, 1, 32'h200);
        check("mp_mispredict", 32'(mispredict), 1);
        check("mp_redirect", redirect_pc, 32'h200);
        tick();
        // FLUSH: no enter, and a stray resolve is ignored without error
        drive(1, 0, 32'h300, 1, 1, 32'h999, 0, 0);
        check("fl_enter", 32'(spec_enter), 0);
        check("fl_stall", 32'(stall_req), 0);
        check("fl_resolve", 32'(spec_resolve), 0);
        tick();
        drive(1, 0, 32'h40, 1, 0, 0, 0, 0);
        check("run_again_enter", 32'(spec_enter), 1);
        check("fl_no_proto", 32'(proto_err), 0);
        tick();

        // Not-taken mispredict
        drive(0, 0, 0, 0, 1, 32'h40, 0, 32'h800);
        check("nt_mispredict", 32'(mispredict), 1);
        check("nt_redirect", redirect_pc, 32'h44);
        tick();
        idle(); tick();

        // Full queue
        drive(1, 0, 32'h10, 1, 0, 0, 0, 0); tick();
        drive(1, 0, 32'h14, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 32'h18, 1, 0, 0, 0, 0);
        check("full_stall", 32'(stall_req), 1);
        check("full_enter", 32'(spec_enter), 0);
        drive(1, 0, 32'h18, 1, 1, 32'h10, 1, 32'h0);
        check("full_pop_stall", 32'(stall_req), 0);
        check("full_pop_enter", 32'(spec_enter), 1);
        tick();
        drive(1, 0, 32'h1c, 0, 0, 0, 0, 0);
        check("still_full_stall", 32'(stall_req), 1);
        tick();
        do_reset();

        // Protocol error
        drive(0, 0, 0, 0, 1, 32'h500, 1, 0);
        check("pe_resolve", 32'(spec_resolve), 0);
        tick();
        idle();
        check("pe_set", 32'(proto_err), 1);
        tick();
        check("pe_held", 32'(proto_err), 1);
        do_reset();
        idle();
        check("pe_cleared", 32'(proto_err), 0);
        tick();

        // Randomized traffic
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] epc;
            bit          eb, et;
            rst = ($urandom_range(0, 199) == 0);
            if (q.size() > 0) begin
                eb  = $urandom_range(0, 1);
                epc = ($urandom_range(0, 19) != 0) ? q[0].pc : {20'd0, 4'($urandom), 8'd0};
                et  = ($urandom_range(0, 4) != 0) ? q[0].pred : 1'($urandom);
            end else begin
                eb  = ($urandom_range(0, 9) == 0);
                epc = {22'd0, 8'($urandom), 2'b00};
                et  = 1'($urandom);
            end
            drive(1'($urandom), ($urandom_range(0, 3) == 0), {22'd0, 8'($urandom), 2'b00},
                  1'($urandom), eb, epc, et, $urandom);
            tick();
        end
        rst = 0;

`ifdef AMA_RISCV_BP_SPEC_STATS_EN
        // Five resolves, two of them mispredicted
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 32'h600 + 32'(k * 4), 1, 0, 0, 0, 0); tick();
            drive(0, 0, 0, 0, 1, 32'h600 + 32'(k * 4), (k < 2) ? 1'b0 : 1'b1, 32'h900);
            tick();
            idle(); tick();
        end
        check("stat_branches_5", stat_branches, 5);
        check("stat_mispred_2", stat_mispred, 2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
